// File: rtl/clk_div_monitor_if.sv
// Monitor-side bundle: divided clock and expected ratio in,
// period measurements and lock/stall status out.
//   div_in, exp_ratio : driven by the source (master)
//   period, high_time, period_valid, symmetric,
//   locked, lol_pulse, stalled : driven by the monitor (slave)
interface clk_div_monitor_if #(
  parameter int CNT_W = 8
);
  logic             div_in;
  logic [CNT_W-1:0] exp_ratio;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             symmetric;
  logic             locked;
  logic             lol_pulse;
  logic             stalled;

  modport master (
    output div_in,
    output exp_ratio,
    input  period,
    input  high_time,
    input  period_valid,
    input  symmetric,
    input  locked,
    input  lol_pulse,
    input  stalled
  );

  modport slave (
    input  div_in,
    input  exp_ratio,
    output period,
    output high_time,
    output period_valid,
    output symmetric,
    output locked,
    output lol_pulse,
    output stalled
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Divided-clock checker: measures period and high time of div_in
// in clk cycles, declares lock on a run of matching periods and
// flags loss of lock and stalled inputs.
// Ports: clk, rst (async, active-high), mon (slave modport).
module clk_div_monitor #(
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  clk_div_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [3:0] LOCK_N = 4'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STALL
  } state_t;

  state_t state;
  state_t state_nxt;

  logic sync1;
  logic sync2;
  logic prev;
  logic rise;
  logic fall;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_hold;

  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             pv_q;
  logic             sym_q;
  logic             locked_q;
  logic             lol_q;
  logic [3:0]       mcnt;

  logic             complete;
  logic             start;
  logic             stall_go;
  logic             match;
  logic [3:0]       mc_inc;
  logic [CNT_W:0]   twice_hi;

  // div_in is asynchronous: two flops for metastability,
  // a third to detect edges on the clean sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= mon.div_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= ONE;
    end else if (cnt != CMAX) begin
      cnt <= cnt + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt <= '0;
    end else if (rise) begin
      hi_cnt <= ONE;
    end else if (sync2 && hi_cnt != CMAX) begin
      hi_cnt <= hi_cnt + ONE;
    end
  end

  // A fresh measurement after IDLE/STALL must not report
  // a high phase left over from before.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_hold <= '0;
    end else if (start) begin
      hi_hold <= '0;
    end else if (fall) begin
      hi_hold <= hi_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    start     = 1'b0;
    stall_go  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          start     = 1'b1;
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          complete = 1'b1;
        end else if (cnt == CMAX) begin
          stall_go  = 1'b1;
          state_nxt = STALL;
        end
      end
      STALL: begin
        if (rise) begin
          start     = 1'b1;
          state_nxt = MEASURE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign match = (cnt == mon.exp_ratio) &&
                 (mon.exp_ratio != '0);

  assign mc_inc = (mcnt == LOCK_N) ? mcnt
                                   : mcnt + 4'd1;

  // One extra bit so 2*high_time cannot wrap onto period.
  assign twice_hi = {hi_hold, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= '0;
      high_q   <= '0;
      sym_q    <= 1'b0;
      pv_q     <= 1'b0;
    end else begin
      pv_q <= complete;
      if (complete) begin
        period_q <= cnt;
        high_q   <= hi_hold;
        sym_q    <= (twice_hi == {1'b0, cnt});
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt     <= '0;
      locked_q <= 1'b0;
      lol_q    <= 1'b0;
    end else begin
      lol_q <= 1'b0;
      if (complete && match) begin
        mcnt     <= mc_inc;
        locked_q <= (mc_inc == LOCK_N);
      end else if (complete || stall_go) begin
        mcnt     <= '0;
        locked_q <= 1'b0;
        lol_q    <= locked_q;
      end
    end
  end

  assign mon.period       = period_q;
  assign mon.high_time    = high_q;
  assign mon.period_valid = pv_q;
  assign mon.symmetric    = sym_q;
  assign mon.locked       = locked_q;
  assign mon.lol_pulse    = lol_q;
  assign mon.stalled      = (state == STALL);

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized bench for clk_div_monitor against a
// waveform-level reference model of periods and lock runs.
module tb_clk_div_monitor;

  localparam int LOCK = 4;
  localparam int PMAX = 255;

  typedef struct packed {
    logic [31:0] at;
    logic [7:0]  p;
    logic [7:0]  h;
    logic        s;
    logic        l;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_div_monitor_if #(.CNT_W(8)) mon();

  clk_div_monitor #(
    .CNT_W(8),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int iter   = 0;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   exp_st_q[$];
  int   obs_st_q[$];
  int   exp_lol;
  int   obs_lol;
  bit   st_seen;

  // reference model state (waveform level)
  int exp_m;
  bit pv_m;
  bit have_ref;
  bit stall_m;
  bit lock_m;
  bit fall_seen;
  int run_m;
  int last_rise;
  int last_fall;

  task automatic model_reset();
    pv_m = 0; have_ref = 0; stall_m = 0;
    lock_m = 0; fall_seen = 0; run_m = 0;
    exp_q.delete(); obs_q.delete();
    exp_st_q.delete(); obs_st_q.delete();
    exp_lol = 0; obs_lol = 0; st_seen = 0;
  endtask

  task automatic step(input bit v);
    rec_t r;
    int p;
    int h;
    bit nl;
    @(posedge clk);
    #1 mon.div_in = v;
    if (v && !pv_m) begin
      if (have_ref && !stall_m) begin
        p = iter - last_rise;
        h = fall_seen ? last_fall - last_rise : 0;
        if (p == exp_m && exp_m != 0) run_m++;
        else run_m = 0;
        nl = (run_m >= LOCK);
        if (lock_m && !nl) exp_lol++;
        lock_m = nl;
        r.at = 32'(iter + 3);
        r.p = 8'(p);
        r.h = 8'(h);
        r.s = (2 * h == p);
        r.l = nl;
        exp_q.push_back(r);
      end
      have_ref = 1; stall_m = 0;
      last_rise = iter; fall_seen = 0;
    end else begin
      if (!v && pv_m) begin
        last_fall = iter; fall_seen = 1;
      end
      if (have_ref && !stall_m &&
          iter - last_rise == PMAX) begin
        stall_m = 1; run_m = 0;
        if (lock_m) exp_lol++;
        lock_m = 0;
        exp_st_q.push_back(iter + 3);
      end
    end
    pv_m = v;
    @(negedge clk);
    if (mon.period_valid) begin
      r.at = 32'(iter);
      r.p = mon.period;
      r.h = mon.high_time;
      r.s = mon.symmetric;
      r.l = mon.locked;
      obs_q.push_back(r);
    end
    if (mon.lol_pulse) obs_lol++;
    if (mon.stalled && !st_seen) obs_st_q.push_back(iter);
    st_seen = mon.stalled;
    iter++;
  endtask

  task automatic run_wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (h) step(1'b1);
      repeat (l) step(1'b0);
    end
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    mon.div_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mon.period, mon.high_time, mon.period_valid,
         mon.symmetric, mon.locked, mon.lol_pulse,
         mon.stalled} !== '0)
      $display("FAIL reset_outs: got p=%0d h=%0d v=%b s=%b l=%b lol=%b st=%b want all 0",
               mon.period, mon.high_time, mon.period_valid,
               mon.symmetric, mon.locked, mon.lol_pulse, mon.stalled);
    else passes++;
  endtask

  task automatic test_idle();
    do_reset();
    exp_m = 4; mon.exp_ratio = 8'd4;
    repeat (60) step(1'b0);
    checks++;
    if (obs_q.size() !== 0 || obs_lol !== 0 || obs_st_q.size() !== 0)
      $display("FAIL idle: got %0d valids %0d lol %0d stalls want 0 0 0",
               obs_q.size(), obs_lol, obs_st_q.size());
    else passes++;
  endtask

  task automatic test_div2();
    do_reset();
    exp_m = 2; mon.exp_ratio = 8'd2;
    run_wave(1, 1, 8);
    repeat (4) step(1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL div2 count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL div2 rec%0d: got %p want %p", i, obs_q[i], exp_q[i]);
      else passes++;
    end
    if (obs_q.size() >= 4) begin
      checks++;
      if (obs_q[2].l !== 1'b0 || obs_q[3].l !== 1'b1 ||
          obs_q[0].p !== 8'd2 || obs_q[0].h !== 8'd1 || obs_q[0].s !== 1'b1)
        $display("FAIL div2 lock4: got %p %p want lock on 4th p=2 h=1 s=1",
                 obs_q[2], obs_q[3]);
      else passes++;
    end
  endtask

  task automatic test_div16();
    do_reset();
    exp_m = 16; mon.exp_ratio = 8'd16;
    run_wave(8, 8, 7);
    repeat (4) step(1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL div16 count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL div16 rec%0d: got %p want %p", i, obs_q[i], exp_q[i]);
      else passes++;
    end
    checks++;
    if (obs_lol !== 0 || mon.locked !== 1'b1)
      $display("FAIL div16 lol: got lol=%0d locked=%b want 0 1", obs_lol, mon.locked);
    else passes++;
  endtask

  task automatic test_mismatch();
    do_reset();
    exp_m = 8; mon.exp_ratio = 8'd8;
    run_wave(4, 4, 6);
    run_wave(2, 2, 6);
    repeat (4) step(1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL mism count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL mism rec%0d: got %p want %p", i, obs_q[i], exp_q[i]);
      else passes++;
    end
    checks++;
    if (obs_lol !== exp_lol || obs_lol !== 1 || mon.locked !== 1'b0)
      $display("FAIL mism lol: got lol=%0d locked=%b want 1 0", obs_lol, mon.locked);
    else passes++;
  endtask

  task automatic test_stall();
    do_reset();
    exp_m = 4; mon.exp_ratio = 8'd4;
    run_wave(2, 2, 6);
    repeat (300) step(1'b0);
    checks++;
    if (mon.stalled !== 1'b1 || mon.locked !== 1'b0)
      $display("FAIL stall hold: got st=%b locked=%b want 1 0", mon.stalled, mon.locked);
    else passes++;
    run_wave(2, 2, 5);
    repeat (4) step(1'b0);
    checks++;
    if (mon.stalled !== 1'b0)
      $display("FAIL stall resume: got st=%b want 0", mon.stalled);
    else passes++;
    checks++;
    if (obs_st_q.size() !== 1 || exp_st_q.size() !== 1 ||
        obs_st_q[0] !== exp_st_q[0])
      $display("FAIL stall entry: got %p want %p", obs_st_q, exp_st_q);
    else passes++;
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL stall count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL stall rec%0d: got %p want %p", i, obs_q[i], exp_q[i]);
      else passes++;
    end
    checks++;
    if (obs_lol !== 1)
      $display("FAIL stall lol: got %0d want 1", obs_lol);
    else passes++;
  endtask

  task automatic test_asym();
    do_reset();
    exp_m = 10; mon.exp_ratio = 8'd10;
    run_wave(3, 7, 7);
    repeat (4) step(1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL asym count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL asym rec%0d: got %p want %p", i, obs_q[i], exp_q[i]);
      else passes++;
    end
    if (obs_q.size() >= 1) begin
      checks++;
      if (obs_q[0].p !== 8'd10 || obs_q[0].h !== 8'd3 || obs_q[0].s !== 1'b0)
        $display("FAIL asym first: got %p want p=10 h=3 s=0", obs_q[0]);
      else passes++;
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    exp_m = 2; mon.exp_ratio = 8'd2;
    run_wave(1, 1, 6);
    repeat (4) step(1'b0);
    checks++;
    if (mon.locked !== 1'b1)
      $display("FAIL midop prelock: got %b want 1", mon.locked);
    else passes++;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mon.period, mon.high_time, mon.period_valid,
         mon.symmetric, mon.locked, mon.lol_pulse,
         mon.stalled} !== '0)
      $display("FAIL midop async: got p=%0d h=%0d l=%b want all 0",
               mon.period, mon.high_time, mon.locked);
    else passes++;
    mon.div_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_wave(1, 1, 6);
    repeat (4) step(1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL midop count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL midop rec%0d: got %p want %p", i, obs_q[i], exp_q[i]);
      else passes++;
    end
    if (obs_q.size() >= 4) begin
      checks++;
      if (obs_q[2].l !== 1'b0 || obs_q[3].l !== 1'b1)
        $display("FAIL midop relock: got %b %b want 0 1", obs_q[2].l, obs_q[3].l);
      else passes++;
    end
  endtask

  task automatic test_random();
    int h;
    int l;
    do_reset();
    exp_m = 5; mon.exp_ratio = 8'd5;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3, 0) != 0) begin
        h = $urandom_range(4, 1);
        l = 5 - h;
      end else begin
        h = $urandom_range(6, 1);
        l = $urandom_range(6, 1);
      end
      run_wave(h, l, 1);
    end
    repeat (4) step(1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL rand count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL rand rec%0d: got %p want %p", i, obs_q[i], exp_q[i]);
      else passes++;
    end
    checks++;
    if (obs_lol !== exp_lol)
      $display("FAIL rand lol: got %0d want %0d", obs_lol, exp_lol);
    else passes++;
  endtask

  initial begin
    mon.div_in = 1'b0;
    mon.exp_ratio = '0;
    model_reset();
    test_reset();
    test_idle();
    test_div2();
    test_div16();
    test_mismatch();
    test_stall();
    test_asym();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
